// File: rtl/ring_noc_pkg.sv
// ring_noc_pkg: shared ring-router constants (packet width, VC ids, requester ids, header fields)
package ring_noc_pkg;
    localparam int   DW      = 64;
    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;
    localparam int   REQ_CW  = 0;
    localparam int   REQ_CCW = 1;
    localparam int   REQ_PE  = 2;
    localparam int   HOP_MSB = 25;
    localparam int   HOP_LSB = 18;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority one-hot picker; pointer moves past the winner on each grant
// ports: clk, reset (async active-low), req candidates, gnt one-hot grant, idx winner index, any grant valid
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);
    logic [PW-1:0] ptr_q, ptr_d;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % N);
    endfunction

    // scanning from the far end lets the candidate closest to the pointer win last
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap(int'(ptr_q) + k)]) begin
                idx = wrap(int'(ptr_q) + k);
                any = 1'b1;
            end
        end
        gnt   = any ? N'(1) << idx : '0;
        ptr_d = any ? wrap(int'(idx) + 1) : ptr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/ring_output_vc_arbiter.sv
// ring_output_vc_arbiter: per-output-port scheduler with even/odd VC slots and polarity
// ports: clk, reset (async active-low), req/req_vc/req_data requester heads, gnt one-hot pop,
//        so/do_data/ro link handshake, polarity current cycle parity, slot_full slot valids
module ring_output_vc_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = ring_noc_pkg::DW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_vc,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic               so,
    output logic [DW-1:0]      do_data,
    input  logic               ro,
    output logic               polarity,
    output logic [1:0]         slot_full
);
    import ring_noc_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic               pol_q, pol_d;
    logic [1:0]         valid_q, valid_d;
    logic [1:0][DW-1:0] data_q, data_d;
    logic               fill_vc;
    logic [NREQ-1:0]    elig;
    logic [PW-1:0]      win;
    logic               win_any;

    assign fill_vc = ~pol_q;
    // gating with reset keeps gnt low while the router is held in reset
    assign elig = req & ~(req_vc ^ {NREQ{fill_vc}}) & {NREQ{reset && !valid_q[fill_vc]}};

    rr_arbiter #(.N(NREQ)) u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (elig),
        .gnt   (gnt),
        .idx   (win),
        .any   (win_any)
    );

    // fill and drain always address opposite slots, so both updates can apply together
    always_comb begin
        pol_d   = ~pol_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q[pol_q] && ro) valid_d[pol_q] = 1'b0;
        if (win_any) begin
            valid_d[fill_vc] = 1'b1;
            data_d[fill_vc]  = req_data[int'(win)*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pol_q   <= VC_EVEN;
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            pol_q   <= pol_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign so        = valid_q[pol_q];
    assign do_data   = data_q[pol_q];
    assign polarity  = pol_q;
    assign slot_full = valid_q;
endmodule

// File: tb/tb_ring_output_vc_arbiter.sv
// tb_ring_output_vc_arbiter: randomized scoreboard bench with a queue-based reference model
module tb_ring_output_vc_arbiter;
    import ring_noc_pkg::*;

    localparam int N = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req, req_vc, gnt;
    logic [N*DW-1:0]  req_data;
    logic             so, ro, polarity;
    logic [DW-1:0]    do_data;
    logic [1:0]       slot_full;

    always #10 clk = ~clk;

    ring_output_vc_arbiter #(.NREQ(N), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_vc    (req_vc),
        .req_data  (req_data),
        .gnt       (gnt),
        .so        (so),
        .do_data   (do_data),
        .ro        (ro),
        .polarity  (polarity),
        .slot_full (slot_full)
    );

    int checks = 0;
    int failures = 0;

    // model: each VC slot is a queue holding at most one packet awaiting the link
    logic [DW-1:0] q0[$], q1[$];
    int       pol = 0;
    int       rr = 0;
    int       fresh = -1;
    logic [N-1:0] last_gnt = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsz(input int v);
        return v != 0 ? q1.size() : q0.size();
    endfunction

    function automatic logic [DW-1:0] qfront(input int v);
        return v != 0 ? q1[0] : q0[0];
    endfunction

    function automatic logic qfull(input int v);
        return (qsz(v) - ((fresh == v) ? 1 : 0)) > 0;
    endfunction

    function automatic logic [N*DW-1:0] pk(input logic [DW-1:0] a, b, c);
        logic [N*DW-1:0] r;
        r = '0;
        r[REQ_CW*DW +: DW]  = a;
        r[REQ_CCW*DW +: DW] = b;
        r[REQ_PE*DW +: DW]  = c;
        return r;
    endfunction

    // stimulus + prediction: a packet is accepted when its VC slot will be empty and it is
    // the first requester on that VC counting round from the fairness pointer
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] v,
                         input logic [N*DW-1:0] d, input logic rdy);
        int fv, win;
        logic [N-1:0] exp_gnt;
        @(negedge clk);
        req = r; req_vc = v; req_data = d; ro = rdy;
        #1;
        fv = 1 - pol;
        win = -1;
        if (qsz(fv) == 0)
            for (int k = 0; k < N; k++)
                if (win < 0 && r[(rr + k) % N] && int'(v[(rr + k) % N]) == fv) win = (rr + k) % N;
        exp_gnt = (win >= 0) ? N'(1) << win : '0;
        chk("gnt", DW'(gnt), DW'(exp_gnt));
        last_gnt = exp_gnt;
        if (win >= 0) begin
            if (fv != 0) q1.push_back(d[win*DW +: DW]);
            else         q0.push_back(d[win*DW +: DW]);
            fresh = fv;
            rr = (win + 1) % N;
        end
    endtask

    task automatic sync_pol(input int want);
        if (pol != want) cycle('0, '0, '0, 1'b1);
    endtask

    // monitor: compares link-side outputs with the model queues and retires sent packets
    always @(negedge clk) begin
        #3;
        if (reset) begin
            chk("polarity", DW'(polarity), DW'(pol));
            chk("slot_full", DW'(slot_full), DW'({qfull(1), qfull(0)}));
            chk("so", DW'(so), DW'(qfull(pol)));
            if (so && qfull(pol)) begin
                chk("do_data", do_data, qfront(pol));
                if (ro) begin
                    if (pol != 0) void'(q1.pop_front());
                    else          void'(q0.pop_front());
                end
            end
            fresh = -1;
            pol ^= 1;
        end
    end

    logic [N-1:0]    cur_r, cur_v;
    logic [N*DW-1:0] cur_d;

    initial begin
        reset = 1'b0; req = '0; req_vc = '0; req_data = '0; ro = 1'b0;
        repeat (2) @(negedge clk);
        #5;
        chk("rst_so", DW'(so), '0);
        chk("rst_gnt", DW'(gnt), '0);
        chk("rst_slot_full", DW'(slot_full), '0);
        chk("rst_polarity", DW'(polarity), '0);
        chk("rst_do_data", do_data, '0);
        @(negedge clk);
        reset = 1'b1;
        // idle after release
        repeat (4) cycle('0, '0, '0, 1'b1);
        // single odd request issued in an even cycle
        sync_pol(0);
        cycle(3'b001, 3'b001, pk(64'hA5, 0, 0), 1'b1);
        repeat (3) cycle('0, '0, '0, 1'b1);
        // round robin, all even
        sync_pol(1);
        repeat (10) cycle(3'b111, 3'b000, pk(1, 2, 3), 1'b1);
        repeat (2) cycle('0, '0, '0, 1'b1);
        // backpressure on the even slot
        sync_pol(1);
        cycle(3'b001, 3'b000, pk(64'hBEEF, 0, 0), 1'b0);
        repeat (6) cycle(3'b001, 3'b000, pk(64'hCAFE, 0, 0), 1'b0);
        repeat (4) cycle(3'b001, 3'b000, pk(64'hCAFE, 0, 0), 1'b1);
        repeat (2) cycle('0, '0, '0, 1'b1);
        // mixed VCs, full link utilisation
        repeat (10) cycle(3'b011, 3'b010, pk(64'h10, 64'h11, 0), 1'b1);
        // fill both slots then reset between edges
        repeat (4) cycle(3'b011, 3'b010, pk(64'h20, 64'h21, 0), 1'b0);
        @(negedge clk);
        #5;
        reset = 1'b0;
        #1;
        chk("mid_rst_slot_full", DW'(slot_full), '0);
        chk("mid_rst_so", DW'(so), '0);
        chk("mid_rst_polarity", DW'(polarity), '0);
        chk("mid_rst_gnt", DW'(gnt), '0);
        q0.delete(); q1.delete();
        pol = 0; rr = 0; fresh = -1; last_gnt = '0;
        @(negedge clk);
        req = '0;
        reset = 1'b1;
        repeat (3) cycle('0, '0, '0, 1'b1);
        // random traffic obeying the hold-until-granted rule
        cur_r = '0; cur_v = '0; cur_d = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!(cur_r[i] && !last_gnt[i])) begin
                    cur_r[i] = 1'($urandom_range(0, 1));
                    cur_v[i] = 1'($urandom_range(0, 1));
                    cur_d[i*DW +: DW] = {$urandom, $urandom};
                end
            end
            cycle(cur_r, cur_v, cur_d, $urandom_range(0, 3) != 0);
        end
        repeat (4) cycle('0, '0, '0, 1'b1);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
